act_pingpong_buffer: RTL and testbench
======================================

// Module: act_pingpong_buffer
// PURPOSE
//   Parametrised double-buffered (ping-pong) activation store between NN layers.
//   The upstream layer fills one bank while the downstream layer reads the other.
//   Banks swap on explicit last-write and read-done handshakes.
//   Adds registered reads, bank-full flow control, an out-of-range error flag and optional fused ReLU.
// PARAMETERS
//   DATA_W  32  activation word width, signed two's complement
//   DEPTH   64  words per bank; total storage is 2*DEPTH
//   ADDR_W  16  address port width; must satisfy 2**ADDR_W >= DEPTH
// PORTS
//   clk        in   1       single clock, all logic on posedge
//   rst_n      in   1       asynchronous, active-low reset
//   wr_en      in   1       write request
//   wr_addr    in   ADDR_W  write address within the current write bank
//   wr_data    in   DATA_W  signed write data
//   wr_last    in   1       qualifies the final write of a layer; valid only with wr_en
//   wr_ready   out  1       current write bank is not full
//   wr_count   out  ADDR_W  in-range writes accepted into the current write bank
//   rd_en      in   1       read request
//   rd_addr    in   ADDR_W  read address within the current read bank
//   rd_done    in   1       pulse: reader releases the current read bank
//   rd_avail   out  1       current read bank is full and readable
//   rd_data    out  DATA_W  registered signed read data
//   rd_valid   out  1       rd_data updated this cycle
//   oob_err    out  1       sticky flag: an out-of-range address was seen
// BEHAVIOUR
//   State
//   - mem[2][DEPTH], full[1:0], wr_sel and rd_sel (1 bit each).
//   - wr_ready = ~full[wr_sel]; rd_avail = full[rd_sel].
//   Reset (rst_n=0, async)
//   - full=0, wr_sel=0, rd_sel=0, wr_count=0, rd_data=0, rd_valid=0, oob_err=0.
//   - Memory contents are not reset and are undefined until written.
//   - Reset mid-fill or mid-read discards all bank state; nothing is flushed.
//   Write side
//   - A write is accepted when wr_en && wr_ready; otherwise it is dropped silently.
//   - Accepted with wr_addr<DEPTH: mem[wr_sel][wr_addr] <= wr_data; wr_count++.
//   - Accepted with wr_addr>=DEPTH: data discarded; oob_err<=1; wr_count unchanged.
//   - Accepted with wr_last=1 (in or out of range): full[wr_sel]<=1, wr_sel<=~wr_sel, wr_count<=0.
//   - wr_last on a dropped write is ignored.
//   Read side
//   - Read latency is 1 cycle: rd_en && rd_avail at edge N gives rd_valid=1 and rd_data at N+1.
//   - rd_data = mem[rd_sel][rd_addr], or 0 with oob_err<=1 if rd_addr>=DEPTH.
//   - rd_en while !rd_avail: rd_valid=0 next cycle; rd_data holds its value.
//   - rd_valid is a single-cycle pulse per accepted read.
//   - rd_done while rd_avail: full[rd_sel]<=0, rd_sel<=~rd_sel. rd_done while !rd_avail is ignored.
//   - rd_en and rd_done in the same cycle: the read is served from the bank being released.
//   Simultaneous events
//   - An accepted wr_last and rd_done in the same cycle always target different banks
//     (the write bank is not full; the read bank is). Both take effect.
//   - Write to bank A and read of bank B in one cycle: independent, no bypass. Same-bank
//     read/write cannot occur by construction.
//   - Both banks full: wr_ready=0 until rd_done frees a bank; wr_ready rises the cycle after.
//   Arithmetic
//   - Data is stored at full DATA_W with no truncation. Address compares are unsigned.
// CONFIGURATION
//   ACT_RELU_EN defined
//   - Fused ReLU on write: stored value = wr_data[DATA_W-1] ? 0 : wr_data.
//   - Zero and positive values pass unchanged.
//   ACT_RELU_EN undefined
//   - wr_data is stored verbatim; negative values are preserved.
// TESTING
//   1. Fill and swap: write addr 0..63 with data=addr, wr_last on 63.
//      -> rd_avail=1, wr_ready=1; read addr 5 -> rd_data=5 one cycle later.
//   2. Back-pressure: fill both banks with no rd_done -> wr_ready=0 and extra writes are dropped.
//      Then rd_done -> wr_ready=1 next cycle; the second bank is readable.
//   3. Out of range: write addr 64 -> oob_err=1, wr_count unchanged.
//      Read addr 70 -> rd_data=0, rd_valid=1.
//   4. ReLU: write 0xFFFFFFF6 (-10) to addr 3 and read it back.
//      -> 0 with ACT_RELU_EN; 0xFFFFFFF6 without.
//   5. Simultaneous: wr_last on bank1 in the same cycle as rd_done on bank0.
//      -> full=2'b10, rd_sel=1, wr_sel=0, rd_avail=1.
//   6. Reset mid-fill after 10 writes -> all outputs at reset values; rd_avail=0; wr_count=0.

Source files
------------

// File: rtl/act_pingpong_buffer.sv
// ---------------------------------------------------------------------------
// act_pingpong_buffer
//   Double-buffered activation store between two NN layers. The producer
//   fills the write bank while the consumer reads the other bank. A bank
//   becomes readable when the producer marks the end of a layer with wr_last.
//   It becomes writable again when the consumer releases it with rd_done.
//
//   Optional build macro: ACT_RELU_EN
//     When defined, negative write data is stored as zero (fused ReLU).
//
// Ports
//   clk       system clock, all logic on posedge
//   rst_n     asynchronous active-low reset
//   wr_en     write request
//   wr_addr   word address within the current write bank
//   wr_data   signed write data
//   wr_last   final write of a layer (only meaningful with wr_en)
//   wr_ready  current write bank is not full
//   wr_count  in-range writes accepted into the current write bank
//   rd_en     read request
//   rd_addr   word address within the current read bank
//   rd_done   reader releases the current read bank
//   rd_avail  current read bank is full and readable
//   rd_data   registered read data (1-cycle latency)
//   rd_valid  single-cycle pulse: rd_data updated
//   oob_err   sticky out-of-range address flag
// ---------------------------------------------------------------------------
module act_pingpong_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] wr_count,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_done,
    output logic              rd_avail,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              oob_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [2][DEPTH];

    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic              wr_sel;
    logic              rd_sel;

    logic              wr_acc;
    logic              wr_in_range;
    logic              rd_acc;
    logic              rd_in_range;
    logic              rd_release;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] wr_store;

    assign wr_ready    = ~full[wr_sel];
    assign rd_avail    = full[rd_sel];

    assign wr_acc      = wr_en & wr_ready;
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_C);
    assign rd_acc      = rd_en & rd_avail;
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_C);
    assign rd_release  = rd_done & rd_avail;

    assign wr_idx      = wr_addr[IDX_W-1:0];
    assign rd_idx      = rd_addr[IDX_W-1:0];

`ifdef ACT_RELU_EN
    assign wr_store = wr_data[DATA_W-1] ? '0 : wr_data;
`else
    assign wr_store = wr_data;
`endif

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc && wr_in_range) begin
            mem[wr_sel][wr_idx] <= wr_store;
        end
    end

    // A completing write and a release always hit different banks (the write
    // bank is never full, the read bank always is), so both can apply.
    always_comb begin
        full_nxt = full;
        if (wr_acc && wr_last) begin
            full_nxt[wr_sel] = 1'b1;
        end
        if (rd_release) begin
            full_nxt[rd_sel] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 2'b00;
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            wr_count <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            oob_err  <= 1'b0;
        end else begin
            full <= full_nxt;

            if (wr_acc && wr_last) begin
                wr_sel   <= ~wr_sel;
                wr_count <= '0;
            end else if (wr_acc && wr_in_range) begin
                wr_count <= wr_count + ADDR_W'(1);
            end

            if (rd_release) begin
                rd_sel <= ~rd_sel;
            end

            // A read in the same cycle as rd_done still uses the old rd_sel.
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= rd_in_range ? mem[rd_sel][rd_idx] : '0;
            end

            if ((wr_acc && !wr_in_range) || (rd_acc && !rd_in_range)) begin
                oob_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_act_pingpong_buffer.sv
module tb_act_pingpong_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 16;

    logic              clk;
    logic              rst_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_count;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_done;
    logic              rd_avail;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              oob_err;

    int n_checks = 0;
    int n_errors = 0;

    act_pingpong_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
        .wr_ready(wr_ready), .wr_count(wr_count),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_done(rd_done),
        .rd_avail(rd_avail), .rd_data(rd_data), .rd_valid(rd_valid),
        .oob_err(oob_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wr_en;
        logic [15:0] wr_addr;
        logic [31:0] wr_data;
        logic        wr_last;
        logic        rd_en;
        logic [15:0] rd_addr;
        logic        rd_done;
        logic        e_wr_ready;
        logic        e_rd_avail;
        logic        e_rd_valid;
        logic [31:0] e_rd_data;
        logic        e_oob;
        logic [15:0] e_wr_count;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [31:0] relu(input logic [31:0] x);
`ifdef ACT_RELU_EN
        return x[31] ? 32'd0 : x;
`else
        return x;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_addr = 0; wr_data = 0; wr_last = 0;
        rd_en = 0; rd_addr = 0; rd_done = 0;
    endtask

    // Inputs change at negedge; outputs are sampled at the following negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 0;
        step();
        rst_n = 1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
        chk({tag, "_rd_avail"}, 32'(rd_avail), 32'd0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_rd_data"},  rd_data, 32'd0);
        chk({tag, "_oob_err"},  32'(oob_err), 32'd0);
        chk({tag, "_wr_count"}, 32'(wr_count), 32'd0);
    endtask

    task automatic fill_bank(input int base);
        for (int a = 0; a < DEPTH; a++) begin
            wr_en = 1; wr_addr = 16'(a); wr_data = 32'(base + a); wr_last = (a == DEPTH - 1);
            step();
            if (a == DEPTH - 2) chk("fill_wr_count", 32'(wr_count), 32'(DEPTH - 1));
        end
        wr_en = 0; wr_last = 0;
    endtask

    // Higher-level reference: layers written/read counters plus a word map.
    int          lw, lr, m_cnt;
    logic        m_oob, e_valid, e_known;
    logic [31:0] e_data;
    logic [31:0] mm [2][DEPTH];
    bit          mk [2][DEPTH];

    task automatic model_reset();
        lw = 0; lr = 0; m_cnt = 0; m_oob = 0;
        e_valid = 0; e_known = 1; e_data = 0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < DEPTH; i++) mk[b][i] = 0;
    endtask

    task automatic model_cycle();
        int nf, wb, rb;
        bit rdy, av;
        nf  = lw - lr;
        rdy = (nf < 2);
        av  = (nf > 0);
        wb  = lw % 2;
        rb  = lr % 2;
        if (rd_en && av) begin
            e_valid = 1;
            if (int'(rd_addr) < DEPTH) begin
                e_known = mk[rb][rd_addr];
                e_data  = mm[rb][rd_addr];
            end else begin
                e_known = 1; e_data = 0; m_oob = 1;
            end
        end else begin
            e_valid = 0;
        end
        if (wr_en && rdy) begin
            if (int'(wr_addr) < DEPTH) begin
                mm[wb][wr_addr] = relu(wr_data);
                mk[wb][wr_addr] = 1;
                m_cnt++;
            end else begin
                m_oob = 1;
            end
            if (wr_last) begin
                lw++;
                m_cnt = 0;
            end
        end
        if (rd_done && av) lr++;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        #12;
        rst_n = 1;
        @(negedge clk);

        // Reset state
        check_reset_outputs("reset");

        // Fill and swap: bank0 holds data == address
        fill_bank(0);
        chk("fill0_rd_avail", 32'(rd_avail), 32'd1);
        chk("fill0_wr_ready", 32'(wr_ready), 32'd1);
        chk("fill0_wr_count", 32'(wr_count), 32'd0);

        vecs[0]  = '{"rd5",          0, 0,  0,           0, 1, 5,  0, 1, 1, 1, 32'd5,  0, 0};
        vecs[1]  = '{"idle_hold",    0, 0,  0,           0, 0, 0,  0, 1, 1, 0, 32'd5,  0, 0};
        vecs[2]  = '{"wr_neg",       1, 3,  32'hFFFFFFF6, 0, 0, 0,  0, 1, 1, 0, 32'd5,  0, 1};
        vecs[3]  = '{"wr_oob",       1, 64, 32'h1234,    0, 0, 0,  0, 1, 1, 0, 32'd5,  1, 1};
        vecs[4]  = '{"rd_oob",       0, 0,  0,           0, 1, 70, 0, 1, 1, 1, 32'd0,  1, 1};
        vecs[5]  = '{"rd63",         0, 0,  0,           0, 1, 63, 0, 1, 1, 1, 32'd63, 1, 1};
        vecs[6]  = '{"last_and_done",1, 7,  32'd77,      1, 1, 10, 1, 1, 1, 1, 32'd10, 1, 0};
        vecs[7]  = '{"rd_relu",      0, 0,  0,           0, 1, 3,  0, 1, 1, 1, relu(32'hFFFFFFF6), 1, 0};
        vecs[8]  = '{"rd_with_done", 0, 0,  0,           0, 1, 7,  1, 1, 0, 1, 32'd77, 1, 0};
        vecs[9]  = '{"rd_not_avail", 0, 0,  0,           0, 1, 7,  0, 1, 0, 0, 32'd77, 1, 0};
        vecs[10] = '{"done_ignored", 0, 0,  0,           0, 0, 0,  1, 1, 0, 0, 32'd77, 1, 0};
        vecs[11] = '{"last_no_en",   0, 5,  32'd9,       1, 0, 0,  0, 1, 0, 0, 32'd77, 1, 0};

        for (int i = 0; i < 12; i++) begin
            wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
            wr_last = vecs[i].wr_last; rd_en = vecs[i].rd_en; rd_addr = vecs[i].rd_addr;
            rd_done = vecs[i].rd_done;
            step();
            chk({vecs[i].name, "_wr_ready"}, 32'(wr_ready), 32'(vecs[i].e_wr_ready));
            chk({vecs[i].name, "_rd_avail"}, 32'(rd_avail), 32'(vecs[i].e_rd_avail));
            chk({vecs[i].name, "_rd_valid"}, 32'(rd_valid), 32'(vecs[i].e_rd_valid));
            chk({vecs[i].name, "_rd_data"},  rd_data, vecs[i].e_rd_data);
            chk({vecs[i].name, "_oob_err"},  32'(oob_err), 32'(vecs[i].e_oob));
            chk({vecs[i].name, "_wr_count"}, 32'(wr_count), 32'(vecs[i].e_wr_count));
        end
        idle_inputs();

        // Back-pressure: both banks full, extra write dropped
        do_reset();
        fill_bank(100);
        fill_bank(200);
        chk("bp_wr_ready", 32'(wr_ready), 32'd0);
        chk("bp_rd_avail", 32'(rd_avail), 32'd1);
        wr_en = 1; wr_addr = 0; wr_data = 32'd999; wr_last = 1;
        rd_en = 1; rd_addr = 0;
        step();
        chk("bp_drop_wr_ready", 32'(wr_ready), 32'd0);
        chk("bp_drop_wr_count", 32'(wr_count), 32'd0);
        chk("bp_rd0", rd_data, 32'd100);
        wr_en = 0; wr_last = 0; rd_en = 0; rd_done = 1;
        step();
        rd_done = 0;
        chk("bp_release_wr_ready", 32'(wr_ready), 32'd1);
        chk("bp_release_rd_avail", 32'(rd_avail), 32'd1);
        chk("bp_release_rd_valid", 32'(rd_valid), 32'd0);
        rd_en = 1; rd_addr = 0;
        step();
        chk("bp_rd_bank1", rd_data, 32'd200);
        chk("bp_rd_bank1_valid", 32'(rd_valid), 32'd1);

        // Reset mid-fill: 10 writes plus an out-of-range one, reads ongoing
        for (int a = 0; a < 11; a++) begin
            wr_en = 1; wr_addr = (a == 10) ? 16'd64 : 16'(a); wr_data = 32'(a + 5);
            rd_en = 1; rd_addr = 16'd1;
            step();
        end
        chk("midfill_wr_count", 32'(wr_count), 32'd10);
        chk("midfill_oob", 32'(oob_err), 32'd1);
        chk("midfill_rd_data", rd_data, 32'd201);
        #2 rst_n = 0;
        #1 check_reset_outputs("async_reset");
        idle_inputs();
        @(negedge clk);
        rst_n = 1;

        // Randomized run against the reference model
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            wr_en   = ($urandom_range(0, 3) != 0);
            wr_addr = 16'($urandom_range(0, 71));
            wr_data = $urandom;
            wr_last = ($urandom_range(0, 19) == 0);
            rd_en   = $urandom_range(0, 1);
            rd_addr = 16'($urandom_range(0, 71));
            rd_done = ($urandom_range(0, 24) == 0);
            model_cycle();
            step();
            chk("rnd_wr_ready", 32'(wr_ready), 32'((lw - lr) < 2));
            chk("rnd_rd_avail", 32'(rd_avail), 32'((lw - lr) > 0));
            chk("rnd_rd_valid", 32'(rd_valid), 32'(e_valid));
            chk("rnd_oob", 32'(oob_err), 32'(m_oob));
            chk("rnd_wr_count", 32'(wr_count), 32'(m_cnt));
            if (e_known) chk("rnd_rd_data", rd_data, e_data);
        end
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
